// File: rtl/mul_add_seq.sv
// -----------------------------------------------------------------------------
// mul_add_seq
//
// Iterative shift-add multiply-accumulate: product = a * b + c, unsigned.
// Consumes the multiplier operand `a` one bit per enabled cycle, MSB first,
// so a result is available N enabled cycles after the operands are accepted.
// Fed with (quotient, divisor, remainder) from the restoring divider it
// rebuilds the original dividend, which makes it the divider's self-check
// and re-packing path.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// en = 1 and both valid and ready are high. Valid, once raised, holds with
// its data until that transfer. Ready never depends combinationally on the
// partner's valid.
//
// Ports
//   clk         in   clock, rising edge
//   rstn        in   asynchronous active-low reset
//   en          in   clock enable; low freezes every register
//   in_valid    in   operands a/b/c valid
//   in_ready    out  block idle and able to accept operands
//   a [N-1:0]   in   multiplier (quotient), sampled at accept
//   b [M-1:0]   in   multiplicand (divisor), sampled at accept
//   c [M-1:0]   in   addend (remainder), sampled at accept
//   out_valid   out  product valid (registered)
//   out_ready   in   consumer takes product
//   product     out  a*b+c, N+M bits (registered, holds after hand-off)
//   busy        out  high while an operation is in RUN or DONE
//   dbg_state_o out  FSM state (0 idle, 1 run, 2 done) for observation
// -----------------------------------------------------------------------------
module mul_add_seq #(
  parameter int N = 4,
  parameter int M = 3
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           en,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [M-1:0]   b,
  input  logic [M-1:0]   c,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N+M-1:0] product,
  output logic           busy,
  output logic [1:0]     dbg_state_o
);

  localparam int W  = N + M;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    a_q, a_d;
  logic [M-1:0]    b_q, b_d;
  logic [M-1:0]    c_q, c_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    product_q, product_d;
  logic            out_valid_q, out_valid_d;

  logic [W-1:0]    b_ext;
  logic [W-1:0]    c_ext;
  logic [W-1:0]    partial;
  logic [W-1:0]    step;
  logic            last_bit;

  // ---------------------------------------------------------------------------
  // Datapath for one RUN step. The addend is folded into the final step so
  // the result appears on the same edge as the last partial product.
  // Max result (2^M-1)*2^N fits in W bits, so no carry out is ever lost.
  // ---------------------------------------------------------------------------
  assign b_ext    = {{N{1'b0}}, b_q};
  assign c_ext    = {{N{1'b0}}, c_q};
  assign last_bit = (cnt_q == '0);
  assign partial  = a_q[cnt_q] ? b_ext : '0;
  assign step     = (acc_q << 1) + partial + (last_bit ? c_ext : '0);

  // ---------------------------------------------------------------------------
  // State register. Everything, including the output flags, freezes with en.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      acc_q       <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else if (en) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      acc_q       <= acc_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    acc_d       = acc_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          c_d     = c;
          acc_d   = '0;
          cnt_d   = CW'(N - 1);
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        acc_d = step;
        if (last_bit) begin
          product_d   = step;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_DONE: begin
        // product is left as is after hand-off; only the flag drops.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: ready/busy decode the state register only.
  // ---------------------------------------------------------------------------
  assign in_ready    = (state_q == S_IDLE);
  assign busy        = (state_q == S_RUN) || (state_q == S_DONE);
  assign out_valid   = out_valid_q;
  assign product     = product_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mul_add_seq.sv
module tb_mul_add_seq;

  localparam int N = 4;
  localparam int M = 3;
  localparam int W = N + M;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic           clk = 1'b0;
  logic           rstn = 1'b1;
  logic           en = 1'b1;
  logic           in_valid = 1'b0;
  logic [N-1:0]   a = '0;
  logic [M-1:0]   b = '0;
  logic [M-1:0]   c = '0;
  logic           out_ready = 1'b1;
  logic           in_ready;
  logic           out_valid;
  logic [W-1:0]   product;
  logic           busy;
  logic [1:0]     dbg_state;

  always #5 clk = ~clk;

  mul_add_seq #(.N(N), .M(M)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .en          (en),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .c           (c),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .product     (product),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard and behavioural model
  // ---------------------------------------------------------------------------
  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] exp_q[$];

  // Model: phase 0 = free, 1 = computing, 2 = holding a result.
  int           m_phase = 0;
  int           m_left  = 0;
  logic         m_valid = 1'b0;
  logic [W-1:0] m_prod  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change at posedge+1, so the values seen at negedge are the ones
  // the next rising edge will use.
  always @(negedge clk) begin
    if (!rstn) begin
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_product",   32'(product),   32'(0));
      check("rst_busy",      32'(busy),      32'(0));
      check("rst_in_ready",  32'(in_ready),  32'(1));
      m_phase = 0;
      m_left  = 0;
      m_valid = 1'b0;
      m_prod  = '0;
      exp_q.delete();
    end else begin
      check("mon_in_ready",  32'(in_ready),  32'(m_phase == 0));
      check("mon_busy",      32'(busy),      32'(m_phase != 0));
      check("mon_out_valid", 32'(out_valid), 32'(m_valid));
      check("mon_product",   32'(product),   32'(m_prod));
      if (en) begin
        case (m_phase)
          0: if (in_valid) begin
            exp_q.push_back(W'(int'(a) * int'(b) + int'(c)));
            m_phase = 1;
            m_left  = N;
          end
          1: begin
            m_left--;
            if (m_left == 0) begin
              if (exp_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL mon_queue: got empty expected 1 entry");
              end else begin
                m_prod = exp_q.pop_front();
              end
              m_valid = 1'b1;
              m_phase = 2;
            end
          end
          2: if (out_ready) begin
            m_valid = 1'b0;
            m_phase = 0;
          end
          default: m_phase = 0;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic do_op(input logic [N-1:0] ta, input logic [M-1:0] tb_v,
                       input logic [M-1:0] tc, input int stall_at,
                       input int stall_len, input int hold_cycles,
                       output int lat, output logic [W-1:0] prod);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("accept_wait", 32'(in_ready), 32'(1));
    a         = ta;
    b         = tb_v;
    c         = tc;
    in_valid  = 1'b1;
    out_ready = (hold_cycles == 0);
    @(posedge clk); #1;                  // accept edge
    in_valid = 1'b0;
    a = N'($urandom);
    b = M'($urandom);
    c = M'($urandom);
    lat = 0;
    while (!out_valid && lat < 60) begin
      check("run_in_ready", 32'(in_ready), 32'(0));
      @(posedge clk); #1;
      lat++;
      if (stall_len > 0 && lat == stall_at) en = 1'b0;
      if (stall_len > 0 && lat == stall_at + stall_len) en = 1'b1;
      if (!en) begin
        a = N'($urandom);
        b = M'($urandom);
        c = M'($urandom);
      end
    end
    check("result_seen", 32'(out_valid), 32'(1));
    prod = product;
    for (int i = 0; i < hold_cycles; i++) begin
      check("hold_valid",    32'(out_valid), 32'(1));
      check("hold_product",  32'(product),   32'(prod));
      check("hold_in_ready", 32'(in_ready),  32'(0));
      @(posedge clk); #1;
    end
    check("done_in_ready", 32'(in_ready), 32'(0));
    out_ready = 1'b1;
    @(posedge clk); #1;                  // result taken
    check("taken_out_valid", 32'(out_valid), 32'(0));
    check("taken_in_ready",  32'(in_ready),  32'(1));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int           lat;
    int           dd;
    int           dv;
    logic [W-1:0] p;

    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    check("reset_in_ready",  32'(in_ready),  32'(1));
    check("reset_product",   32'(product),   32'(0));
    check("reset_out_valid", 32'(out_valid), 32'(0));

    // Basic
    do_op(4'd5, 3'd3, 3'd2, 0, 0, 0, lat, p);
    check("basic_product", 32'(p), 32'(17));
    check("basic_latency", 32'(lat), 32'(4));

    // Extremes
    do_op(4'd15, 3'd7, 3'd7, 0, 0, 0, lat, p);
    check("max_product", 32'(p), 32'(112));
    do_op(4'd0, 3'd0, 3'd0, 0, 0, 0, lat, p);
    check("zero_product", 32'(p), 32'(0));
    do_op(4'd15, 3'd7, 3'd0, 0, 0, 0, lat, p);
    check("maxab_product", 32'(p), 32'(105));

    // Backpressure
    do_op(4'd9, 3'd6, 3'd4, 0, 0, 10, lat, p);
    check("bp_product", 32'(p), 32'(58));
    check("bp_latency", 32'(lat), 32'(4));

    // Enable stall of 3 cycles mid-RUN
    do_op(4'd6, 3'd5, 3'd1, 2, 3, 0, lat, p);
    check("stall_product", 32'(p), 32'(31));
    check("stall_latency", 32'(lat), 32'(7));

    // Reset in the 2nd RUN cycle
    a = 4'd7; b = 3'd7; c = 3'd0; in_valid = 1'b1;
    @(posedge clk); #1;                  // accept
    in_valid = 1'b0;
    @(posedge clk); #1;                  // second RUN cycle
    rstn = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'(0));
    check("midrst_product",   32'(product),   32'(0));
    check("midrst_busy",      32'(busy),      32'(0));
    check("midrst_in_ready",  32'(in_ready),  32'(1));
    @(posedge clk); #1;
    rstn = 1'b1;
    do_op(4'd2, 3'd3, 3'd1, 0, 0, 0, lat, p);
    check("postrst_product", 32'(p), 32'(7));
    check("postrst_latency", 32'(lat), 32'(4));

    // Divider round-trip
    for (int i = 0; i < 200; i++) begin
      dd = $urandom_range(0, 15);
      dv = $urandom_range(1, 7);
      do_op(N'(dd / dv), M'(dv), M'(dd % dv), 0, 0, $urandom_range(0, 2), lat, p);
      check("roundtrip", 32'(p), 32'(dd));
    end

    // Free-running random traffic with enable and backpressure noise
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      en        = ($urandom_range(0, 7) != 0);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      a = N'($urandom);
      b = M'($urandom);
      c = M'($urandom);
    end
    @(posedge clk); #1;
    en = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (N + 4) @(posedge clk);
    #1;
    check("drain_in_ready", 32'(in_ready), 32'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_add_seq.md
# mul_add_seq

Iterative shift-add multiply-accumulate unit computing `product = a * b + c`. It is the inverse of the pipelined restoring divider. Fed with quotient, divisor and remainder, it reconstructs the original dividend, so it serves as the datapath's self-check and re-packing path. It processes the multiplier operand one bit per cycle, MSB first, mirroring the divider's bit order, and uses valid/ready handshakes on both sides.

## Interface
- `N`, default 4: width of operand `a` (quotient / dividend width).
- `M`, default 3: width of operands `b` and `c` (divisor / remainder width).
- `clk`  in  1: clock; all state changes on the rising edge.
- `rstn`  in  1: reset, asynchronous, active-low.
- `en`  in  1: clock enable. When low, all registers hold, including state, counter, accumulator and output flags.
- `in_valid`  in  1: operands valid.
- `in_ready`  out  1: block can accept operands. Equals (state == IDLE).
- `a`  in  N: multiplier operand, sampled at accept.
- `b`  in  M: multiplicand operand, sampled at accept.
- `c`  in  M: addend, sampled at accept.
- `out_valid`  out  1: `product` valid. Registered.
- `out_ready`  in  1: consumer takes result.
- `product`  out  N+M: result. Registered.
- `busy`  out  1: high in RUN or DONE.

## Operation
- **States:** IDLE, RUN, DONE. Reset state is IDLE.
- **Reset values:** `out_valid` = 0, `product` = 0, `busy` = 0, `in_ready` = 1. Internal accumulator = 0, bit counter = 0, operand registers = 0.
- **IDLE:**
  - Accept occurs at an enabled edge with `in_valid` && `in_ready`.
  - On accept: latch `a`, `b`, `c`; set accumulator = 0; set counter = N-1; go to RUN.
- **RUN, each enabled edge:**
  - acc <= (acc << 1) + (a[cnt] ? {0, b} : 0).
  - On the edge where cnt == 0, also add zero-extended `c` in the same step. Then `product` <= that value, `out_valid` <= 1, go to DONE.
  - Otherwise cnt <= cnt - 1.
- **DONE:**
  - Hold `product` and `out_valid` until an enabled edge with `out_ready` = 1.
  - At that edge: `out_valid` <= 0, go to IDLE. `product` keeps its last value; it is not cleared.
- **Width rule:** all arithmetic is N+M bits, unsigned. The maximum result is (2^N-1)(2^M-1) + (2^M-1) = (2^M-1)·2^N < 2^(N+M), so overflow is impossible and no saturation logic is present.
- **Input changes:** `a`, `b`, `c` changing after accept have no effect on the operation in flight.
- **`in_valid` outside IDLE:** ignored, since `in_ready` = 0.
- **`out_ready` outside DONE:** ignored.
- **Reset mid-operation:** asserting `rstn` low in any state immediately returns all outputs to their reset values. The operation in flight is discarded and no result is emitted.
- **`en` low:** freezes the block in any state. While `en` = 0 no handshake completes, even if valid and ready are both high.

## Timing
- The accept edge is E0. RUN edges are E1..EN. `out_valid` goes high after edge EN, i.e. N enabled cycles after the accept edge (4 cycles at default N).
- With `out_ready` held high, DONE lasts one cycle. `in_ready` rises the cycle after the result is taken.
- Minimum issue interval is N+2 enabled cycles. There is no overlap between operations.
- `in_ready` is combinational from the state register only. It has no combinational path from `in_valid` or `out_ready`.
- `busy` is combinational from state.

## Test plan
- **Basic:** reset; a=5, b=3, c=2, `in_valid` one cycle -> `out_valid` rises exactly 4 cycles after accept with `product` = 17. `in_ready` = 0 through RUN and DONE.
- **Extremes:**
  - a=15, b=7, c=7 -> `product` = 112.
  - a=0, b=0, c=0 -> `product` = 0.
  - a=15, b=7, c=0 -> `product` = 105.
- **Backpressure:** a=9, b=6, c=4 with `out_ready` = 0 for 10 cycles -> `product` = 58 stable and `out_valid` = 1 throughout; then `out_ready` = 1 -> `out_valid` drops next edge and `in_ready` = 1.
- **Enable stall:** a=6, b=5, c=1, with `en` deasserted for 3 cycles in mid-RUN -> `out_valid` rises 7 cycles after accept with `product` = 31. Operand changes during the stall are ignored.
- **Reset mid-op:** a=7, b=7, assert `rstn` low at the 2nd RUN cycle -> all outputs return to reset values immediately. After release, a=2, b=3, c=1 -> `product` = 7 with normal latency.
- **Divider round-trip:** random dividends 0..15 and divisors 1..7 are divided, then (quotient, divisor, remainder) is fed in -> `product` equals the original dividend for 200 vectors.
